// File: rtl/gc_mem_pkg.sv
// gc_mem_pkg: shared refresh FSM states and statistics counter width
// for the refreshed gain-cell memory wrapper.
package gc_mem_pkg;

  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REF_RD = 2'd1,
    REF_WB = 2'd2
  } ref_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gc_dram_array.sv
// gc_dram_array: DATA_W x DEPTH storage, synchronous write and
// registered 1-cycle read on independent ports; no reset on contents.
module gc_dram_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read samples the array before the same-edge write lands.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/refresh_mem_wrapper.sv
// refresh_mem_wrapper: row-by-row refresh of a gain-cell array arbitrated
// against user traffic. Define REFRESH_STATS_EN for refresh/urgent counters.
module refresh_mem_wrapper
  import gc_mem_pkg::*;
#(
  parameter int DATA_W           = 64,
  parameter int DEPTH            = 128,
  parameter int REFRESH_INTERVAL = 1024,
  parameter int MAX_DEFER        = 8,
  localparam int ADDR_W          = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] in,
  output logic              ready,
  output logic [DATA_W-1:0] rd,
  output logic              rd_valid,
  output logic              refresh_busy,
`ifdef REFRESH_STATS_EN
  output logic              refresh_miss,
  output logic [STAT_W-1:0] refresh_cnt,
  output logic [STAT_W-1:0] urgent_cnt
`else
  output logic              refresh_miss
`endif
);

  localparam int CNT_W = (REFRESH_INTERVAL > 1) ?
                         $clog2(REFRESH_INTERVAL) : 1;
  localparam int DEF_W = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;

  localparam logic [CNT_W-1:0]  RELOAD   = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [DEF_W-1:0]  DEF_MAX  = DEF_W'(MAX_DEFER);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(DEPTH - 1);

  ref_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ref_row_q, ref_row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEF_W-1:0]  defer_q, defer_d;
  logic              pend_q, pend_d;
  logic              miss_q, miss_d;
  logic              rdv_q, rdv_d;

  logic              expiry, urgent, idle, start, wb_done;
  logic              user_rd, user_wr;

  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_waddr, arr_raddr;
  logic [DATA_W-1:0] arr_wdata, arr_rdata;

  assign expiry  = (cnt_q == '0);
  assign urgent  = (defer_q == DEF_MAX);
  assign idle    = (state_q == IDLE);
  assign wb_done = (state_q == REF_WB);
  assign ready   = !rst && idle && !urgent;
  assign user_rd = ready && re;
  assign user_wr = ready && we;
  assign start   = idle && pend_q && (urgent || (!re && !we));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = REF_RD;
      REF_RD:  state_d = REF_WB;
      REF_WB:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = expiry ? RELOAD : cnt_q - 1'b1;
    pend_d    = pend_q;
    defer_d   = defer_q;
    ref_row_d = ref_row_q;
    miss_d    = miss_q | (expiry & pend_q);
    rdv_d     = user_rd;
    if (wb_done) begin
      pend_d    = 1'b0;
      defer_d   = '0;
      ref_row_d = (ref_row_q == ROW_LAST) ? '0 : ref_row_q + 1'b1;
    end else if (idle && pend_q && !start && !urgent) begin
      defer_d = defer_q + 1'b1;
    end
    // A fresh expiry re-arms the request even as a refresh retires.
    if (expiry) pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ref_row_q <= '0;
      cnt_q     <= RELOAD;
      pend_q    <= 1'b0;
      defer_q   <= '0;
      miss_q    <= 1'b0;
      rdv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_row_q <= ref_row_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      defer_q   <= defer_d;
      miss_q    <= miss_d;
      rdv_q     <= rdv_d;
    end
  end

  assign arr_re    = user_rd || (state_q == REF_RD);
  assign arr_raddr = (state_q == REF_RD) ? ref_row_q : raddr;
  assign arr_we    = user_wr || wb_done;
  assign arr_waddr = wb_done ? ref_row_q : waddr;
  assign arr_wdata = wb_done ? arr_rdata : in;

  gc_dram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .raddr_i (arr_raddr),
    .rdata_o (arr_rdata)
  );

  assign rd           = rdv_q ? arr_rdata : '0;
  assign rd_valid     = rdv_q;
  assign refresh_busy = !idle;
  assign refresh_miss = miss_q;

`ifdef REFRESH_STATS_EN
  logic [STAT_W-1:0] rcnt_q, ucnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q <= '0;
      ucnt_q <= '0;
    end else begin
      if (wb_done)          rcnt_q <= sat_inc(rcnt_q);
      if (start && urgent)  ucnt_q <= sat_inc(ucnt_q);
    end
  end

  assign refresh_cnt = rcnt_q;
  assign urgent_cnt  = ucnt_q;
`endif

endmodule

// File: tb/tb_refresh_mem_wrapper.sv
// tb_refresh_mem_wrapper: directed stimulus with a read-data scoreboard
// for refresh_mem_wrapper (DEPTH=8, interval 16).
module tb_refresh_mem_wrapper;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0, re = 1'b0;
  logic [AW-1:0] waddr = '0, raddr = '0;
  logic [DW-1:0] din = '0;
  logic          ready, rd_valid, busy, miss;
  logic [DW-1:0] rd;

  logic          m_rst = 1'b1;
  logic          m_re = 1'b0;
  logic          m_ready, m_rd_valid, m_busy, m_miss;
  logic [DW-1:0] m_rd;

`ifdef REFRESH_STATS_EN
  logic [15:0] rcnt, ucnt, m_rcnt, m_ucnt;
`endif

  int n_pass = 0;
  int n_total = 0;
  int edges = 0;
  int base = 0;

  logic [DW-1:0] model [8];
  logic [DW-1:0] q [$];

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  refresh_mem_wrapper #(
    .DATA_W(DW), .DEPTH(8), .REFRESH_INTERVAL(16), .MAX_DEFER(4)
  ) u_dut (
    .clk(clk), .rst(rst), .we(we), .re(re),
    .waddr(waddr), .raddr(raddr), .in(din),
    .ready(ready), .rd(rd), .rd_valid(rd_valid),
    .refresh_busy(busy),
`ifdef REFRESH_STATS_EN
    .refresh_miss(miss), .refresh_cnt(rcnt), .urgent_cnt(ucnt)
`else
    .refresh_miss(miss)
`endif
  );

  refresh_mem_wrapper #(
    .DATA_W(DW), .DEPTH(8), .REFRESH_INTERVAL(16), .MAX_DEFER(16)
  ) u_miss (
    .clk(clk), .rst(m_rst), .we(1'b0), .re(m_re),
    .waddr(3'd0), .raddr(3'd1), .in(32'd0),
    .ready(m_ready), .rd(m_rd), .rd_valid(m_rd_valid),
    .refresh_busy(m_busy),
`ifdef REFRESH_STATS_EN
    .refresh_miss(m_miss), .refresh_cnt(m_rcnt), .urgent_cnt(m_ucnt)
`else
    .refresh_miss(m_miss)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard push: expected read data taken before a same-cycle write.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (re) q.push_back(model[raddr]);
      if (we) model[waddr] = din;
    end
  end

  // Monitor: every presented read is popped and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (q.size() == 0) chk("rd_unexpected", 64'(rd_valid), 64'd0);
        else chk("rd_data", 64'(rd), 64'(q.pop_front()));
      end else begin
        chk("rd_zero", 64'(rd), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_pos(input int n);
    while (edges - base < n) tick();
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b1;
    we = 1'b0;
    re = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (check) begin
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd", 64'(rd), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_miss", 64'(miss), 64'd0);
    end
    tick();
    rst = 1'b0;
    base = edges;
    q.delete();
  endtask

  task automatic wait_ref(output int ns, output int row, output int len);
    ns = -1;
    row = -1;
    len = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) begin
        ns = edges - base;
        row = int'(u_dut.ref_row_q);
        break;
      end
    end
    if (ns >= 0) begin
      len = 1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!busy) break;
        len++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, row, len;

    do_reset(1'b1);
    for (int r = 0; r < 8; r++) begin
      we = 1'b1;
      waddr = 3'(r);
      din = (r == 5) ? 32'h1 : 32'h100 + 32'(r);
      tick();
    end
    we = 1'b0;
    tick();

    // Idle refresh cadence: rows 0..7 then 0, every 16 cycles.
    do_reset(1'b0);
    for (int k = 0; k < 9; k++) begin
      wait_ref(ns, row, len);
      chk("ref_start", 64'(ns), 64'(17 + 16 * k));
      chk("ref_row", 64'(row), 64'(k % 8));
      chk("ref_len", 64'(len), 64'd2);
    end

    // Write then read row 3; re-read after its refresh.
    do_reset(1'b0);
    we = 1'b1;
    waddr = 3'd3;
    din = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    re = 1'b1;
    raddr = 3'd3;
    tick();
    re = 1'b0;
    @(negedge clk);
    chk("wr_rd_valid", 64'(rd_valid), 64'd1);
    chk("wr_rd_data", 64'(rd), 64'hDEAD_BEEF);
    to_pos(70);
    chk("row3_refreshed", 64'(u_dut.ref_row_q), 64'd4);
    re = 1'b1;
    raddr = 3'd3;
    tick();
    re = 1'b1;
    raddr = 3'd5;
    we = 1'b1;
    waddr = 3'd5;
    din = 32'h2;
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("rw_old", 64'(rd), 64'h1);
    tick();
    re = 1'b0;
    @(negedge clk);
    chk("rw_new", 64'(rd), 64'h2);

    // Continuous reads from cycle 10: urgent preemption.
    do_reset(1'b0);
    to_pos(9);
    re = 1'b1;
    for (int n = 9; n <= 25; n++) begin
      raddr = 3'(n % 8);
      @(negedge clk);
      chk("urg_ready", 64'(ready), (n >= 20 && n <= 22) ? 64'd0 : 64'd1);
      if (n == 21 || n == 22) chk("urg_busy", 64'(busy), 64'd1);
      tick();
    end
    re = 1'b0;
    tick();
`ifdef REFRESH_STATS_EN
    chk("urgent_cnt", 64'(ucnt), 64'd1);
    chk("refresh_cnt", 64'(rcnt), 64'd1);
`endif

    // Reset during write-back of row 2.
    do_reset(1'b0);
    to_pos(50);
    chk("wb_busy", 64'(busy), 64'd1);
    chk("wb_row", 64'(u_dut.ref_row_q), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd", 64'(rd), 64'd0);
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_miss", 64'(miss), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    base = edges;
    q.delete();
    wait_ref(ns, row, len);
    chk("post_rst_start", 64'(ns), 64'd17);
    chk("post_rst_row", 64'(row), 64'd0);
    re = 1'b1;
    raddr = 3'd2;
    tick();
    re = 1'b0;
    @(negedge clk);
    chk("row2_kept", 64'(rd), 64'h102);
    tick();

    // Second expiry while still pending latches refresh_miss.
    m_re = 1'b1;
    m_rst = 1'b0;
    base = edges;
    to_pos(31);
    @(negedge clk);
    chk("miss_before", 64'(m_miss), 64'd0);
    @(negedge clk);
    chk("miss_set", 64'(m_miss), 64'd1);
    m_re = 1'b0;
    to_pos(80);
    chk("miss_sticky", 64'(m_miss), 64'd1);
    m_rst = 1'b1;
    #1;
    chk("miss_cleared", 64'(m_miss), 64'd0);

    tick();
    tick();
    chk("sb_drain", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
